packet_assembler: RTL and testbench
===================================

// Module: packet_assembler
// PURPOSE
//  Transmit-side counterpart of the node's packet filter. Control logic (reward,
//  knownCH, myNodeInfo) requests a packet of type HB/CHE/INV/MR/CHT/DATA/SOS.
//  The block latches the header and payload words, then serializes them MSB-first
//  into a byte stream toward the radio/TX buffer using a valid/ready handshake.
//  Byte layout: [type][len][srcH][srcL][dstH][dstL][payload words, big-endian].
// PARAMETERS
//  WORD_WIDTH  16  width of node IDs and payload words
//  BYTE_WIDTH  8   width of the output byte stream
//  MAX_WORDS   4   payload word slots (w0..w3)
// PORTS
//  clk            in   1   clock, rising edge
//  nrst           in   1   reset, synchronous, active-low
//  tx_req         in   1   request to send; sampled only in IDLE
//  tx_type        in   3   packet type (000 HB .. 110 SOS; 111 illegal)
//  myNodeID       in   16  source ID, latched on accept
//  destinationID  in   16  destination ID, latched on accept
//  w0,w1,w2,w3    in   16  payload words, latched on accept
//  tx_data        out  8   current byte
//  tx_valid       out  1   tx_data valid
//  tx_ready       in   1   downstream accepts byte when tx_valid&&tx_ready
//  tx_last        out  1   high with the final byte of the packet
//  busy           out  1   high from accept cycle+1 until done pulse
//  tx_done        out  1   one-cycle pulse after last byte handshake
//  tx_err         out  1   one-cycle pulse: tx_req with tx_type=111
//  tx_count       out  16  completed-packet counter, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (nrst=0 at clk edge): state IDLE; tx_data=0, tx_valid=0, tx_last=0,
//   busy=0, tx_done=0, tx_err=0, tx_count=0; latched fields cleared.
//  Payload words N per type: HB=4 (hopsFromSink,e_min,e_max,e_threshold);
//   CHE=1 (CH_ID); INV=3 (CH_ID,hopsFromCH,CHQValue); MR=1 (QValue);
//   CHT=1 (timeslot); DATA=3, SOS=3 (energy,QValue,data). Unused w* ignored.
//  len byte = 2*N (payload bytes only). Total bytes = 6+2N (8..14).
//  type byte = {5'b0,tx_type}.
//  FSM: IDLE -> SEND -> DONE -> IDLE.
//   IDLE: tx_req && tx_type!=111 -> latch all inputs, byte index=0, go SEND.
//         tx_req && tx_type==111 -> tx_err=1 next cycle, stay IDLE.
//   SEND: tx_valid=1; tx_data = byte[index]; index advances only on
//         tx_valid&&tx_ready; tx_data/tx_last held stable while tx_ready=0.
//         tx_last=1 iff index==5+2N. Handshake on last byte -> DONE.
//   DONE: tx_valid=0, tx_done=1 for one cycle, tx_count+=1, -> IDLE.
//  Latency: accept edge -> first byte valid on next cycle; with tx_ready
//   tied high, 6+2N data cycles then done pulse; next tx_req accepted in
//   the cycle after tx_done (IDLE).
//  tx_req during SEND/DONE ignored (not queued); inputs may change freely
//   after accept without affecting the packet in flight.
//  Reset mid-packet: packet dropped, no tx_done, tx_count cleared.
//  tx_count wraps modulo 2^16; no saturation.
// TESTING
//  1 CHE, myNodeID=0x0012, dst=0xFFFF, w0=0x0007, ready=1 -> bytes
//    01 02 00 12 FF FF 00 07; tx_last on 8th; tx_done next; tx_count=1.
//  2 HB, w0..w3=0x0001,0x0100,0x0A00,0x0200 -> 14 bytes, len=08,
//    payload 00 01 01 00 0A 00 02 00.
//  3 DATA with tx_ready toggling 1,0,0,1,... -> each byte held unchanged while
//    ready=0; sequence identical to ready=1 run; no byte lost/duplicated.
//  4 tx_type=111 in IDLE -> tx_err pulse 1 cycle, tx_valid stays 0, count same.
//  5 second tx_req + changed w0 during SEND -> in-flight bytes unchanged,
//    second request not sent.
//  6 nrst low at byte 4 of INV -> all outputs 0 next cycle, no tx_done;
//    fresh MR request afterwards sends 8 bytes correctly.

Source files
------------

// File: rtl/packet_assembler.sv
// Latches a requested packet (header plus type-dependent payload words) and streams it
// out MSB-first as bytes over a valid/ready interface, pulsing tx_done when the packet is complete.
module packet_assembler #(
  parameter int WORD_WIDTH = 16,
  parameter int BYTE_WIDTH = 8,
  parameter int MAX_WORDS  = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  tx_req,
  input  logic [2:0]            tx_type,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] destinationID,
  input  logic [WORD_WIDTH-1:0] w0,
  input  logic [WORD_WIDTH-1:0] w1,
  input  logic [WORD_WIDTH-1:0] w2,
  input  logic [WORD_WIDTH-1:0] w3,
  output logic [BYTE_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  tx_err,
  output logic [15:0]           tx_count,
  output logic [1:0]            state_dbg
);

  // Handshake: a byte moves on any rising edge where tx_valid && tx_ready. While
  // tx_valid is high and tx_ready low, tx_data and tx_last hold their values.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            type_q;
  logic [WORD_WIDTH-1:0] src_q, dst_q;
  logic [WORD_WIDTH-1:0] w_q [MAX_WORDS];
  logic [3:0]            idx_q;
  logic [15:0]           count_q;
  logic                  err_q;
  logic [2:0]            n_words;
  logic [3:0]            last_idx;
  logic                  accept;
  logic                  handshake;

  assign accept    = (state_q == IDLE) && tx_req && (tx_type != 3'b111);
  assign handshake = (state_q == SEND) && tx_ready;
  assign last_idx  = 4'd5 + {n_words, 1'b0};

  always_comb begin
    n_words = 3'd3;
    case (type_q)
      3'd0:                n_words = 3'd4;
      3'd1, 3'd3, 3'd4:    n_words = 3'd1;
      default:             n_words = 3'd3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (handshake && (idx_q == last_idx)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      type_q  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      for (int i = 0; i < MAX_WORDS; i++) w_q[i] <= '0;
      idx_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == IDLE) && tx_req && (tx_type == 3'b111);
      if (accept) begin
        type_q <= tx_type;
        src_q  <= myNodeID;
        dst_q  <= destinationID;
        w_q[0] <= w0;
        w_q[1] <= w1;
        w_q[2] <= w2;
        w_q[3] <= w3;
        idx_q  <= '0;
      end else if (handshake && (idx_q != last_idx)) begin
        idx_q <= idx_q + 4'd1;
      end
      if (state_q == DONE) count_q <= count_q + 16'd1;
    end
  end

  // Payload words are sent big-endian: even index carries the high byte.
  always_comb begin
    tx_data = '0;
    if (state_q == SEND) begin
      case (idx_q)
        4'd0:    tx_data = {{(BYTE_WIDTH-3){1'b0}}, type_q};
        4'd1:    tx_data = {{(BYTE_WIDTH-4){1'b0}}, n_words, 1'b0};
        4'd2:    tx_data = src_q[WORD_WIDTH-1 -: BYTE_WIDTH];
        4'd3:    tx_data = src_q[BYTE_WIDTH-1:0];
        4'd4:    tx_data = dst_q[WORD_WIDTH-1 -: BYTE_WIDTH];
        4'd5:    tx_data = dst_q[BYTE_WIDTH-1:0];
        4'd6:    tx_data = w_q[0][WORD_WIDTH-1 -: BYTE_WIDTH];
        4'd7:    tx_data = w_q[0][BYTE_WIDTH-1:0];
        4'd8:    tx_data = w_q[1][WORD_WIDTH-1 -: BYTE_WIDTH];
        4'd9:    tx_data = w_q[1][BYTE_WIDTH-1:0];
        4'd10:   tx_data = w_q[2][WORD_WIDTH-1 -: BYTE_WIDTH];
        4'd11:   tx_data = w_q[2][BYTE_WIDTH-1:0];
        4'd12:   tx_data = w_q[3][WORD_WIDTH-1 -: BYTE_WIDTH];
        4'd13:   tx_data = w_q[3][BYTE_WIDTH-1:0];
        default: tx_data = '0;
      endcase
    end
  end

  assign tx_valid  = (state_q == SEND);
  assign tx_last   = (state_q == SEND) && (idx_q == last_idx);
  assign busy      = (state_q != IDLE);
  assign tx_done   = (state_q == DONE);
  assign tx_err    = err_q;
  assign tx_count  = count_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_packet_assembler.sv
// Bench for packet_assembler: table of known packets, hand-written corner sequences,
// and random packets checked against a byte-list model built from the packet layout.
module tb_packet_assembler;

  logic        clk = 1'b0;
  logic        nrst;
  logic        tx_req;
  logic [2:0]  tx_type;
  logic [15:0] myNodeID, destinationID, w0, w1, w2, w3;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_last, busy, tx_done, tx_err;
  logic [15:0] tx_count;
  logic [1:0]  state_dbg;

  packet_assembler dut (
    .clk(clk), .nrst(nrst), .tx_req(tx_req), .tx_type(tx_type),
    .myNodeID(myNodeID), .destinationID(destinationID),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .busy(busy), .tx_done(tx_done), .tx_err(tx_err), .tx_count(tx_count),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         exp_count = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [2:0]   t;
    logic [15:0]  src;
    logic [15:0]  dst;
    logic [63:0]  w;
    int           nb;
    logic [111:0] bytes;
    int           mode;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int n_of(input logic [2:0] t);
    case (t)
      3'd0:             return 4;
      3'd1, 3'd3, 3'd4: return 1;
      default:          return 3;
    endcase
  endfunction

  task automatic build_exp(input logic [2:0] t, input logic [15:0] src, input logic [15:0] dst,
                           input logic [63:0] w);
    int n;
    logic [15:0] word;
    n = n_of(t);
    exp_q.delete();
    exp_q.push_back(8'(t));
    exp_q.push_back(8'(2 * n));
    exp_q.push_back(8'(src / 256));
    exp_q.push_back(8'(src % 256));
    exp_q.push_back(8'(dst / 256));
    exp_q.push_back(8'(dst % 256));
    for (int i = 0; i < n; i++) begin
      word = 16'(w >> (48 - 16 * i));
      exp_q.push_back(8'(word / 256));
      exp_q.push_back(8'(word % 256));
    end
  endtask

  // mode: 0 ready always high, 1 ready pattern 1,0,0 repeating, 2 random ready.
  // disturb: raise tx_req and alter inputs mid-packet. abort_at: assert reset when that
  // many bytes have been accepted (-1 = never).
  task automatic run_packet(input logic [2:0] t, input logic [15:0] src, input logic [15:0] dst,
                            input logic [63:0] w, input int mode, input int disturb,
                            input int abort_at);
    int         hs;
    int         cyc;
    logic       rdy;
    logic       prev_pend;
    logic [7:0] prev_d;
    logic [7:0] e;
    logic       finished;
    hs = 0; cyc = 0; prev_pend = 1'b0; prev_d = '0; finished = 1'b0;
    @(negedge clk);
    tx_type = t; myNodeID = src; destinationID = dst; {w0, w1, w2, w3} = w;
    tx_req = 1'b1; tx_ready = 1'b0;
    @(negedge clk);
    tx_req = 1'b0;
    chk("busy_after_accept", busy, 1);
    while (!finished && cyc < 100) begin
      chk("valid_in_send", tx_valid, 1);
      if (prev_pend) chk("hold_data", tx_data, prev_d);
      if (disturb != 0 && cyc == 2) begin
        tx_req = 1'b1; w0 = 16'hDEAD; myNodeID = 16'hBAD0; tx_type = 3'd0;
      end
      if (disturb != 0 && cyc == 4) tx_req = 1'b0;
      if (abort_at >= 0 && hs == abort_at) begin
        nrst = 1'b0;
        tx_ready = 1'b0;
        return;
      end
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = (cyc % 3 == 0);
      else rdy = 1'($urandom_range(0, 1));
      tx_ready = rdy;
      if (tx_valid && rdy) begin
        if (exp_q.size() == 0) begin
          chk("extra_byte", 1, 0);
          finished = 1'b1;
        end else begin
          e = exp_q.pop_front();
          chk("byte", tx_data, e);
          chk("last_flag", tx_last, exp_q.size() == 0);
          hs++;
          prev_pend = 1'b0;
          if (exp_q.size() == 0) finished = 1'b1;
        end
      end else begin
        prev_pend = tx_valid;
        prev_d = tx_data;
      end
      cyc++;
      @(negedge clk);
    end
    if (!finished) chk("packet_timeout", 1, 0);
    chk("all_bytes_sent", exp_q.size(), 0);
    chk("done_pulse", tx_done, 1);
    chk("valid_low_in_done", tx_valid, 0);
    exp_count++;
    @(negedge clk);
    chk("done_one_cycle", tx_done, 0);
    chk("busy_idle", busy, 0);
    chk("tx_count", tx_count, 32'(16'(exp_count)));
  endtask

  initial begin
    vecs[0] = '{3'd1, 16'h0012, 16'hFFFF, 64'h0007_0000_0000_0000, 8,
                {64'h01_02_00_12_FF_FF_00_07, 48'h0}, 0};
    vecs[1] = '{3'd0, 16'h1234, 16'h5678, 64'h0001_0100_0A00_0200, 14,
                112'h00_08_12_34_56_78_00_01_01_00_0A_00_02_00, 0};
    vecs[2] = '{3'd4, 16'hABCD, 16'h0001, 64'hBEEF_1111_2222_3333, 8,
                {64'h04_02_AB_CD_00_01_BE_EF, 48'h0}, 0};
    vecs[3] = '{3'd6, 16'h0102, 16'h0304, 64'h1111_2222_3333_4444, 12,
                {96'h06_06_01_02_03_04_11_11_22_22_33_33, 16'h0}, 0};
    vecs[4] = '{3'd5, 16'h00AA, 16'h00BB, 64'h0102_0304_0506_0708, 12,
                {96'h05_06_00_AA_00_BB_01_02_03_04_05_06, 16'h0}, 0};
    vecs[5] = '{3'd5, 16'h00AA, 16'h00BB, 64'h0102_0304_0506_0708, 12,
                {96'h05_06_00_AA_00_BB_01_02_03_04_05_06, 16'h0}, 1};

    nrst = 1'b0; tx_req = 1'b0; tx_type = '0; tx_ready = 1'b0;
    myNodeID = '0; destinationID = '0; w0 = '0; w1 = '0; w2 = '0; w3 = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_err", tx_err, 0);
    chk("rst_count", tx_count, 0);
    chk("rst_state", state_dbg, 0);
    nrst = 1'b1;

    for (int v = 0; v < 6; v++) begin
      exp_q.delete();
      for (int b = 0; b < vecs[v].nb; b++) exp_q.push_back(vecs[v].bytes[111 - 8 * b -: 8]);
      run_packet(vecs[v].t, vecs[v].src, vecs[v].dst, vecs[v].w, vecs[v].mode, 0, -1);
    end

    // Illegal type: error pulse only.
    @(negedge clk);
    tx_type = 3'b111; tx_req = 1'b1;
    @(negedge clk);
    tx_req = 1'b0;
    chk("err_pulse", tx_err, 1);
    chk("err_no_valid", tx_valid, 0);
    chk("err_not_busy", busy, 0);
    @(negedge clk);
    chk("err_one_cycle", tx_err, 0);
    chk("err_valid_still_low", tx_valid, 0);
    chk("err_count_same", tx_count, 32'(16'(exp_count)));

    // Request and input changes during SEND must not disturb the packet or queue another.
    build_exp(3'd3, 16'h4455, 16'h6677, 64'h8899_0000_0000_0000);
    run_packet(3'd3, 16'h4455, 16'h6677, 64'h8899_0000_0000_0000, 0, 1, -1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_second_packet", tx_valid, 0);
    end

    // Reset in the middle of an INV packet.
    build_exp(3'd2, 16'h0A0B, 16'h0C0D, 64'h0001_0002_0003_0000);
    run_packet(3'd2, 16'h0A0B, 16'h0C0D, 64'h0001_0002_0003_0000, 0, 0, 4);
    @(negedge clk);
    chk("midrst_valid", tx_valid, 0);
    chk("midrst_data", tx_data, 0);
    chk("midrst_last", tx_last, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", tx_done, 0);
    chk("midrst_count", tx_count, 0);
    nrst = 1'b1;
    exp_count = 0;
    @(negedge clk);
    chk("midrst_no_done", tx_done, 0);
    build_exp(3'd3, 16'h0F0E, 16'h0D0C, 64'h1357_0000_0000_0000);
    run_packet(3'd3, 16'h0F0E, 16'h0D0C, 64'h1357_0000_0000_0000, 0, 0, -1);

    // Random packets with random back-pressure.
    for (int r = 0; r < 25; r++) begin
      logic [2:0]  t;
      logic [15:0] s, d;
      logic [63:0] w;
      t = 3'($urandom_range(0, 6));
      s = 16'($urandom);
      d = 16'($urandom);
      w = {32'($urandom), 32'($urandom)};
      build_exp(t, s, d, w);
      run_packet(t, s, d, w, 2, 0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
